// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, datapath
// select codes, opcode classes, DP commands and condition codes.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWR,
    MEMWB,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH,
    ILLEGAL
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // NV (1111) is treated as always-execute on this datapath.
  function automatic logic condPass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: condPass = z;
      COND_NE: condPass = ~z;
      COND_CS: condPass = c;
      COND_CC: condPass = ~c;
      COND_MI: condPass = n;
      COND_PL: condPass = ~n;
      COND_VS: condPass = v;
      COND_VC: condPass = ~v;
      COND_HI: condPass = c & ~z;
      COND_LS: condPass = ~c | z;
      COND_GE: condPass = (n == v);
      COND_LT: condPass = (n != v);
      COND_GT: condPass = ~z & (n == v);
      COND_LE: condPass = z | (n != v);
      default: condPass = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Instruction fields, ALU flags and datapath strobes exchanged between the
// multicycle controller (master) and the datapath (slave).
interface mc_controller_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;

  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] RegSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       Illegal;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Illegal
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Illegal
  );
endinterface

// File: rtl/mc_controller_cond_unit.sv
// NZCV flag register with condition evaluation and gated flag writes.
// condHeld remembers the previous cycle's verdict so a writeback state can
// act on the pre-update flags of its own execute cycle.
module cond_unit
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic       flagReq,
  input  logic       cvReq,
  input  logic       useHeld,
  output logic       CondEx
);

  logic [3:0] nzcv;
  logic       condLive;
  logic       condHeld;

  assign condLive = condPass(Cond, nzcv);
  assign CondEx   = useHeld ? condHeld : condLive;

  // NZ follow any permitted flag write; CV only for arithmetic commands.
  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv     <= 4'b0000;
      condHeld <= 1'b0;
    end else begin
      condHeld <= condLive;
      if (flagReq && condLive) begin
        nzcv[3:2] <= ALUFlags[3:2];
        if (cvReq) nzcv[1:0] <= ALUFlags[1:0];
      end
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the shared-ALU ARM datapath (LDR/STR/DP/B).
// Define MC_ILLEGAL_TRAP_EN to trap Op=11 into a sticky Illegal flag.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  mc_controller_if.master bus
);

  state_t     state, nextState;
  logic [3:0] cmd;
  logic       isImm, sBit, lBit, uBit;
  logic       cmdKnown, cmdIsCmp, cmdHasCarry;
  logic [2:0] cmdAlu;
  logic       condEx, flagReq, cvReq, useHeld;
  logic       pcWriteRaw, memWriteRaw, regWriteRaw, irWriteRaw;

  assign cmd   = bus.Funct[4:1];
  assign isImm = bus.Funct[5];
  assign uBit  = bus.Funct[3];
  assign sBit  = bus.Funct[0];
  assign lBit  = bus.Funct[0];

  // Unknown commands fall back to ADD and never write the register file.
  always_comb begin
    cmdAlu      = ALU_ADD;
    cmdKnown    = 1'b1;
    cmdIsCmp    = 1'b0;
    cmdHasCarry = 1'b0;
    case (cmd)
      CMD_ADD: begin cmdAlu = ALU_ADD; cmdHasCarry = 1'b1; end
      CMD_SUB: begin cmdAlu = ALU_SUB; cmdHasCarry = 1'b1; end
      CMD_CMP: begin cmdAlu = ALU_SUB; cmdHasCarry = 1'b1; cmdIsCmp = 1'b1; end
      CMD_AND: cmdAlu = ALU_AND;
      CMD_ORR: cmdAlu = ALU_ORR;
      default: cmdKnown = 1'b0;
    endcase
  end

  assign useHeld = (state == ALUWB);

  cond_unit uCond (
    .clk     (clk),
    .reset   (reset),
    .Cond    (bus.Cond),
    .ALUFlags(bus.ALUFlags),
    .flagReq (flagReq),
    .cvReq   (cvReq),
    .useHeld (useHeld),
    .CondEx  (condEx)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  always_comb begin
    nextState      = state;
    pcWriteRaw     = 1'b0;
    memWriteRaw    = 1'b0;
    regWriteRaw    = 1'b0;
    irWriteRaw     = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = SRCB_RD2;
    bus.ResultSrc  = RES_ALUOUT;
    bus.ALUControl = ALU_ADD;
    flagReq        = 1'b0;
    cvReq          = 1'b0;
    case (state)
      FETCH: begin
        irWriteRaw    = 1'b1;
        pcWriteRaw    = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        nextState     = DECODE;
      end
      DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        case (bus.Op)
          OP_MEM:  nextState = MEMADR;
          OP_DP:   nextState = isImm ? EXECI : EXECR;
          OP_BR:   nextState = BRANCH;
`ifdef MC_ILLEGAL_TRAP_EN
          default: nextState = ILLEGAL;
`else
          default: nextState = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        bus.ALUSrcB    = SRCB_IMM;
        bus.ALUControl = uBit ? ALU_ADD : ALU_SUB;
        nextState      = lBit ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.AdrSrc = 1'b1;
        nextState  = MEMWB;
      end
      MEMWR: begin
        bus.AdrSrc  = 1'b1;
        memWriteRaw = condEx;
        nextState   = FETCH;
      end
      MEMWB: begin
        bus.ResultSrc = RES_DATA;
        regWriteRaw   = condEx;
        pcWriteRaw    = condEx && (bus.Rd == 4'hF);
        nextState     = FETCH;
      end
      EXECR, EXECI: begin
        bus.ALUSrcB    = (state == EXECI) ? SRCB_IMM : SRCB_RD2;
        bus.ALUControl = cmdAlu;
        flagReq        = sBit || cmdIsCmp;
        cvReq          = cmdHasCarry;
        nextState      = ALUWB;
      end
      ALUWB: begin
        regWriteRaw = condEx && cmdKnown && !cmdIsCmp;
        pcWriteRaw  = condEx && cmdKnown && !cmdIsCmp && (bus.Rd == 4'hF);
        nextState   = FETCH;
      end
      BRANCH: begin
        bus.ALUSrcB   = SRCB_IMM;
        bus.ResultSrc = RES_ALURESULT;
        pcWriteRaw    = condEx;
        nextState     = FETCH;
      end
      default: nextState = FETCH;
    endcase
  end

  // Register-source and immediate selects depend only on the latched instruction.
  assign bus.RegSrc = {(bus.Op == OP_MEM) && !lBit, bus.Op == OP_BR};
  assign bus.ImmSrc = bus.Op;

  assign bus.PCWrite  = pcWriteRaw  & ~reset;
  assign bus.MemWrite = memWriteRaw & ~reset;
  assign bus.RegWrite = regWriteRaw & ~reset;
  assign bus.IRWrite  = irWriteRaw  & ~reset;

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegalReg;

  always_ff @(posedge clk) begin
    if (reset)                 illegalReg <= 1'b0;
    else if (state == ILLEGAL) illegalReg <= 1'b1;
  end

  assign bus.Illegal = illegalReg;
`else
  assign bus.Illegal = 1'b0;
`endif

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control unit that sequences a shared-ALU/shared-memory ARM datapath variant (single ALU, single memory port, IR/Data/ALUOut registers).
- Decodes the ARM subset LDR/STR/DP/B, holds the NZCV flag register and evaluates the condition field.
- Drives all datapath select and write-enable strobes, one FSM state per cycle.

Parameters:
- none (encodings are fixed in mc_pkg)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]: I, opcode/PUBWL, S/L
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- PCWrite  out  1  PC register enable
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register-file write strobe
- IRWrite  out  1  instruction-register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- RegSrc  out  2  same meaning as single-cycle RegSrc: [0]=RA1 is R15, [1]=RA2 is Rd
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ImmSrc  out  2  00=DP imm8, 01=mem imm12, 10=branch imm24
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR
- Illegal  out  1  sticky undefined-instruction flag

Behaviour:
- Reset (synchronous, active-high):
  - On the next edge: state=FETCH, NZCV=0000, Illegal=0.
  - While reset is high, PCWrite, MemWrite, RegWrite and IRWrite are forced to 0 regardless of state.
  - Reset asserted in any state aborts the instruction with no further writes.
- States and transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR if Op=01; EXECR if Op=00 and I=0; EXECI if Op=00 and I=1; BRANCH if Op=10; Op=11 see Optional Feature.
  - MEMADR -> MEMRD if L=1, otherwise MEMWR.
  - MEMRD -> MEMWB.
  - EXECR and EXECI -> ALUWB.
  - MEMWB, MEMWR, ALUWB and BRANCH -> FETCH.
- Latency per instruction: LDR 5 cycles; STR 4; DP 4; B 3.
- Outputs by state:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 unconditionally.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10 (PC+8 for the R15 read). RegSrc[0]=1 for B; RegSrc[1]=1 for STR; ImmSrc=Op.
  - MEMADR: ALUSrcA=0, ALUSrcB=01; ADD if U=Funct[3]=1, otherwise SUB.
  - MEMRD: AdrSrc=1.
  - MEMWR: AdrSrc=1, MemWrite=CondEx.
  - MEMWB: ResultSrc=01, RegWrite=CondEx.
  - EXECR: ALUSrcB=00; ALUControl from cmd=Funct[4:1]: 0100 ADD, 0010 SUB, 1010 SUB (CMP), 0000 AND, 1100 ORR. Any other cmd: ADD with RegWrite suppressed.
  - EXECI: as EXECR but ALUSrcB=01.
  - ALUWB: ResultSrc=00, RegWrite=CondEx and cmd!=CMP.
  - BRANCH: ALUSrcA=0 (RA1=R15 reads PC+8), ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx.
- PC-relative writeback: any RegWrite with Rd=15 (MEMWB/ALUWB) also asserts PCWrite=CondEx; the register write itself still occurs.
- CondEx: combinational from Cond and the stored NZCV using ARM semantics (EQ..AL; 1111 treated as AL).
- Flags:
  - Updated on the clock edge ending EXECR/EXECI, only if S=Funct[0]=1 and CondEx=1.
  - NZ are always written.
  - CV are written only for ADD/SUB/CMP.
  - CMP with S=0 is still forced to write flags.
- Evaluation timing: CondEx is evaluated with pre-update flags in every state, so an instruction never sees its own flag update.

Optional Feature:
- Macro MC_ILLEGAL_TRAP_EN.
- Defined: Op=11 in DECODE -> state ILLEGAL.
  - ILLEGAL sets Illegal=1 (sticky until reset) and asserts no strobes.
  - ILLEGAL -> FETCH. Instruction latency is 3 cycles.
- Undefined: Op=11 executes as a NOP (DECODE -> FETCH, 2 cycles). Illegal is tied 0.

Decomposition:
- Package mc_pkg holds:
  - state enum (FETCH..ILLEGAL);
  - ALUControl, ALUSrcB, ResultSrc and ImmSrc encodings;
  - Op codes;
  - DP cmd constants;
  - condition-code constants.
- One sub-module, cond_unit: NZCV register plus CondEx evaluation and flag-write gating. The FSM and output decode stay in mc_controller.

Test Plan:
- Reset held 2 cycles mid-LDR (state MEMRD) -> next state FETCH, NZCV=0, no RegWrite/MemWrite pulse during or after reset.
- LDR R1,[R2,#4] (Cond=1110, Op=01, Funct=011001) -> FETCH, DECODE, MEMADR (ADD), MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1), then FETCH; 5 cycles total.
- SUBS R3,R3,#1 producing ALUFlags=0100, followed by BNE -> Z=1 stored; the BNE passes through BRANCH with PCWrite=0 and returns to FETCH.
- STR with Cond=0000 (EQ) and Z=0 -> MEMWR with MemWrite=0; 4 cycles total.
- ADD R15,R0,R1 (Rd=15) -> ALUWB asserts RegWrite=1 and PCWrite=1.
- Op=11 -> with MC_ILLEGAL_TRAP_EN: Illegal=1 after the ILLEGAL state and stays 1 until reset. Without the macro: 2-cycle NOP and Illegal=0.
